// File: rtl/qos_ingress.sv
// qos_ingress: frames an ingress byte stream into packets and steers each into one of four class FIFOs.
module qos_ingress #(
    parameter int NCLASS = 4,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        DATA_IN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [NCLASS-1:0] ALMOST_FULL,
    input  logic [NCLASS-1:0] FULL,
    output logic [NCLASS-1:0] PUSH,
    output logic [7:0]        PUSH_DATA,
    output logic              BUSY,
    output logic [CNT_W-1:0]  PKT_CNT,
    output logic [CNT_W-1:0]  DROP_CNT
);
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t         state;
    logic [1:0]     cls;
    logic [LEN_W:0] remaining;
    logic           accept;
    logic [1:0]     hdr_cls;

    assign hdr_cls = DATA_IN[7:6];
    // A push still in flight may take the last slot that ALMOST_FULL advertises.
    assign IN_READY = (state == FWD) ? ~FULL[cls] & ~(PUSH[cls] & ALMOST_FULL[cls]) : 1'b1;
    assign accept   = IN_VALID & IN_READY;
    assign BUSY     = state != IDLE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            PUSH      <= '0;
            PUSH_DATA <= '0;
            PKT_CNT   <= '0;
            DROP_CNT  <= '0;
            remaining <= '0;
            cls       <= '0;
        end else begin
            PUSH <= '0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        cls       <= hdr_cls;
                        remaining <= {1'b0, DATA_IN[LEN_W-1:0]} + 1'b1;
                        if (!ALMOST_FULL[hdr_cls]) begin
                            PUSH      <= NCLASS'(1) << hdr_cls;
                            PUSH_DATA <= DATA_IN;
                            PKT_CNT   <= PKT_CNT + 1'b1;
                            state     <= FWD;
                        end else begin
                            DROP_CNT <= (&DROP_CNT) ? DROP_CNT : DROP_CNT + 1'b1;
                            state    <= DROP;
                        end
                    end
                    FWD: begin
                        PUSH      <= NCLASS'(1) << cls;
                        PUSH_DATA <= DATA_IN;
                        remaining <= remaining - 1'b1;
                        state     <= (remaining == 1) ? IDLE : FWD;
                    end
                    default: begin
                        remaining <= remaining - 1'b1;
                        state     <= (remaining == 1) ? IDLE : DROP;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qos_ingress.sv
// tb_qos_ingress: scoreboard bench for qos_ingress; expected pushes are queued on acceptance and matched at the DUT output.
module tb_qos_ingress;
    logic       CLK = 0, RESET = 1, IN_VALID = 0;
    logic [7:0] DATA_IN = 0;
    logic [3:0] ALMOST_FULL = 0, FULL = 0;
    logic       IN_READY, BUSY;
    logic [3:0] PUSH;
    logic [7:0] PUSH_DATA, PKT_CNT, DROP_CNT;

    qos_ingress dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALMOST_FULL(ALMOST_FULL), .FULL(FULL), .PUSH(PUSH), .PUSH_DATA(PUSH_DATA),
        .BUSY(BUSY), .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {int cyc; logic [3:0] push; logic [7:0] data;} exp_t;
    exp_t sb[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0, last_wait = 0, pkt_wait = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte and holds it until accepted; called at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit fwd, input logic [1:0] c);
        logic rdy;
        DATA_IN   = b;
        IN_VALID  = 1;
        last_wait = 0;
        forever begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            #1;
            if (rdy) break;
            last_wait++;
            if (last_wait > 50) begin
                chk("ready_timeout", 0, 1);
                break;
            end
        end
        if (rdy && fwd) sb.push_back('{cyc, 4'b0001 << c, b});
        pkt_wait += last_wait;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n, input bit fwd, input logic [7:0] base);
        send_byte(hdr, fwd, hdr[7:6]);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), fwd, hdr[7:6]);
    endtask

    task automatic idle(input int n);
        IN_VALID = 0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (PUSH != 0) begin
            exp_t e;
            if (sb.size() == 0) chk("unexpected_push", {PUSH, PUSH_DATA}, 0);
            else begin
                e = sb.pop_front();
                chk("push_cycle", cyc, e.cyc);
                chk("push", {PUSH, PUSH_DATA}, {e.push, e.data});
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        chk("rst_push", PUSH, 0);
        chk("rst_data", PUSH_DATA, 0);
        chk("rst_pkt", PKT_CNT, 0);
        chk("rst_drop", DROP_CNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", IN_READY, 1);

        // basic forward, class 1, len 3
        pkt_wait = 0;
        send_pkt(8'h42, 3, 1, 8'hA1);
        idle(2);
        chk("t1_wait", pkt_wait, 0);
        chk("t1_pkt", PKT_CNT, 1);
        chk("t1_busy", BUSY, 0);

        // dropped packet on class 3
        ALMOST_FULL = 4'b1000;
        pkt_wait = 0;
        send_pkt(8'hC0, 1, 0, 8'h55);
        chk("t2_ready_wait", pkt_wait, 0);
        idle(2);
        ALMOST_FULL = 0;
        chk("t2_drop", DROP_CNT, 1);
        chk("t2_pkt", PKT_CNT, 1);
        chk("t2_busy", BUSY, 0);

        // class 0 len 8 with a 5-cycle FULL stall after the 3rd payload byte
        send_byte(8'h07, 1, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1, 0);
        FULL[0]  = 1;
        DATA_IN  = 8'h33;
        IN_VALID = 1;
        repeat (5) begin
            @(negedge CLK);
            chk("t3_stall_ready", IN_READY, 0);
        end
        @(posedge CLK);
        #1;
        FULL[0] = 0;
        send_byte(8'h33, 1, 0);
        chk("t3_resume_wait", last_wait, 0);
        for (int i = 4; i < 8; i++) send_byte(8'h30 + 8'(i), 1, 0);
        idle(2);
        chk("t3_pkt", PKT_CNT, 2);
        chk("t3_busy", BUSY, 0);

        // in-flight push with ALMOST_FULL on the current class must stall
        send_byte(8'h81, 1, 2);
        ALMOST_FULL[2] = 1;
        @(negedge CLK);
        chk("t3b_inflight_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        send_byte(8'h50, 1, 2);
        chk("t3b_after_wait", last_wait, 0);
        ALMOST_FULL[2] = 0;
        send_byte(8'h51, 1, 2);
        idle(2);
        chk("t3b_pkt", PKT_CNT, 3);

        // back-to-back packets, no bubble
        pkt_wait = 0;
        send_pkt(8'h00, 1, 1, 8'h11);
        send_pkt(8'h80, 1, 1, 8'h22);
        chk("t4_wait", pkt_wait, 0);
        idle(2);
        chk("t4_pkt", PKT_CNT, 5);

        // reset in mid-packet
        send_byte(8'h09, 1, 0);
        send_byte(8'h60, 1, 0);
        send_byte(8'h61, 1, 0);
        RESET    = 1;
        IN_VALID = 0;
        @(posedge CLK);
        #1;
        RESET = 0;
        chk("t5_push", PUSH, 0);
        chk("t5_busy", BUSY, 0);
        chk("t5_pkt", PKT_CNT, 0);
        chk("t5_drop", DROP_CNT, 0);
        send_pkt(8'h41, 2, 1, 8'h70);
        idle(2);
        chk("t5_new_pkt", PKT_CNT, 1);
        chk("t5_new_busy", BUSY, 0);

        // drop counter saturation
        ALMOST_FULL = 4'hF;
        for (int i = 0; i < 300; i++) begin
            send_pkt(8'h00, 1, 0, 8'hEE);
            if (i == 253) chk("t6_drop_254", DROP_CNT, 254);
            if (i == 254) chk("t6_drop_255", DROP_CNT, 255);
        end
        idle(2);
        chk("t6_drop_sat", DROP_CNT, 255);
        chk("t6_pkt", PKT_CNT, 1);

        idle(5);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
